// File: rtl/timestamp_reader.sv
// SPI host-side reader for the timestamper CPLD: arms capture, waits for INT, shifts the count in MSB first.
// Optional TSR_SYNC_EN adds 2-flop synchronizers on INT and SDO.
module timestamp_reader #(
  parameter int WIDTH    = 16,
  parameter int SCLK_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             INT,
  input  logic             SDO,
  output logic             SCLK,
  output logic             CE_N,
  output logic             RSTCAPT,
  output logic [WIDTH-1:0] DATA,
  output logic             DATA_VALID,
  input  logic             DATA_READY,
  output logic             BUSY
);

  localparam int CW = $clog2(2 * SCLK_DIV + 3) + 1;
  localparam int BW = $clog2(WIDTH) + 1;

  localparam logic [CW-1:0] C_HALF  = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] C_ARM   = CW'(2 * SCLK_DIV - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(2);
  localparam logic [BW-1:0] B_LAST  = BW'(WIDTH);

  typedef enum logic [2:0] {
    IDLE, ARM, BLANK, WAIT_INT, SETUP, SHIFT, HOLD, DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [BW-1:0]    r_bits, w_bits_nxt;
  logic             r_phase_hi, w_phase_hi_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_ce_n, w_ce_n_nxt;
  logic             r_rstcapt;
  logic             r_busy;
  logic             w_int;
  logic             w_sdo;

`ifdef TSR_SYNC_EN
  logic r_int_s1, r_int_s2, r_sdo_s1, r_sdo_s2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_int_s1 <= 1'b0;
      r_int_s2 <= 1'b0;
      r_sdo_s1 <= 1'b0;
      r_sdo_s2 <= 1'b0;
    end else begin
      r_int_s1 <= INT;
      r_int_s2 <= r_int_s1;
      r_sdo_s1 <= SDO;
      r_sdo_s2 <= r_sdo_s1;
    end
  end

  assign w_int = r_int_s2;
  assign w_sdo = r_sdo_s2;
`else
  assign w_int = INT;
  assign w_sdo = SDO;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + CW'(1);
    w_bits_nxt     = r_bits;
    w_phase_hi_nxt = r_phase_hi;
    w_shift_nxt    = r_shift;
    w_data_nxt     = r_data;
    w_valid_nxt    = r_valid;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (EN) w_state_nxt = ARM;
      end
      ARM: begin
        if (r_cnt == C_ARM) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
        end
      end
      BLANK: begin
        if (r_cnt == C_BLANK) begin
          w_state_nxt = WAIT_INT;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_INT: begin
        w_cnt_nxt = '0;
        if (w_int) begin
          w_state_nxt    = SETUP;
          w_bits_nxt     = '0;
          w_phase_hi_nxt = 1'b0;
        end
      end
      SETUP: begin
        if (r_cnt == C_HALF) begin
          w_state_nxt    = SHIFT;
          w_cnt_nxt      = '0;
          w_phase_hi_nxt = 1'b1;
        end
      end
      SHIFT: begin
        // Sample on the last cycle of the high phase; terminate after the last low phase.
        if (r_cnt == C_HALF) begin
          w_cnt_nxt = '0;
          if (r_phase_hi) begin
            w_phase_hi_nxt = 1'b0;
            w_shift_nxt    = {r_shift[WIDTH-2:0], w_sdo};
            w_bits_nxt     = r_bits + BW'(1);
          end else if (r_bits == B_LAST) begin
            w_state_nxt = HOLD;
          end else begin
            w_phase_hi_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (r_cnt == C_HALF) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
          w_data_nxt  = r_shift;
          w_valid_nxt = 1'b1;
        end
      end
      DONE: begin
        w_cnt_nxt = '0;
        if (DATA_READY && r_valid) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = EN ? ARM : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_sclk_nxt = (w_state_nxt == SHIFT) && w_phase_hi_nxt;
    w_ce_n_nxt = !((w_state_nxt == SETUP) || (w_state_nxt == SHIFT) ||
                   (w_state_nxt == HOLD));
  end

  // Pin outputs are registered from next-state so they switch with the state;
  // RSTCAPT follows the ARM state one cycle late, giving a full ARM-length pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bits     <= '0;
      r_phase_hi <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sclk     <= 1'b0;
      r_ce_n     <= 1'b1;
      r_rstcapt  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bits     <= w_bits_nxt;
      r_phase_hi <= w_phase_hi_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_sclk     <= w_sclk_nxt;
      r_ce_n     <= w_ce_n_nxt;
      r_rstcapt  <= (r_state == ARM);
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign SCLK       = r_sclk;
  assign CE_N       = r_ce_n;
  assign RSTCAPT    = r_rstcapt;
  assign DATA       = r_data;
  assign DATA_VALID = r_valid;
  assign BUSY       = r_busy;

endmodule

// File: tb/tb_timestamp_reader.sv
// Bench for timestamp_reader (WIDTH=8, SCLK_DIV=4) with a behavioural timestamper model.
module tb_timestamp_reader;

  localparam int W = 8;
  localparam int D = 4;
`ifdef TSR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         int_i;
  logic         sdo;
  logic         sclk, ce_n, rstcapt, data_valid, busy;
  logic [W-1:0] data;
  logic         data_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  // timestamper model state
  logic [W-1:0] cap = 8'h5A;
  logic         pending = 1'b1;
  logic         int_glitch = 1'b0;
  logic [W-1:0] cap_val = '0;
  int           cap_seq = 0;
  int           seen = 0;
  logic         prev_sclk = 1'b0;
  logic         prev_ce = 1'b1;
  int           idx = 7;

  timestamp_reader #(.WIDTH(W), .SCLK_DIV(D)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .INT(int_i), .SDO(sdo),
    .SCLK(sclk), .CE_N(ce_n), .RSTCAPT(rstcapt), .DATA(data),
    .DATA_VALID(data_valid), .DATA_READY(data_ready), .BUSY(busy)
  );

  always #5 clk = ~clk;

  assign int_i = pending ^ int_glitch;
  assign sdo   = cap[idx[2:0]];

  always @(posedge clk) begin
    prev_sclk <= sclk;
    prev_ce   <= ce_n;
    if (prev_ce && !ce_n) idx <= W - 1;
    else if (prev_sclk && !sclk && !ce_n && idx > 0) idx <= idx - 1;
    if (cap_seq != seen) begin
      seen <= cap_seq;
      if (!pending && !rstcapt) begin
        cap     <= cap_val;
        pending <= 1'b1;
      end
    end
    if (rstcapt) pending <= 1'b0;
  end

  always @(negedge clk) if (sclk && ce_n) viol++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_arm(output int n);
    int g;
    g = 0;
    while (!rstcapt && g < 200) begin @(negedge clk); g++; end
    chk("arm_seen", (g < 200), 1);
    n = 0;
    while (rstcapt && n < 200) begin n++; @(negedge clk); end
    repeat (4) @(negedge clk);
  endtask

  task automatic read_frame(input logic [W-1:0] v, input string tag);
    int n, low, rises, first;
    logic ps;
    @(negedge clk);
    cap_val = v;
    cap_seq++;
    @(posedge clk);
    n = 0;
    while (ce_n && n <= 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_int_to_ce"}, n, LAT);
    low = 1; rises = 0; first = -1; ps = sclk;
    while (!ce_n && low < 500) begin
      @(posedge clk); #1;
      if (sclk && !ps) begin
        rises++;
        if (first < 0) first = low;
      end
      ps = sclk;
      if (!ce_n) low++;
    end
    chk({tag, "_ce_low"}, low, D * (2 * W + 2));
    chk({tag, "_pulses"}, rises, W);
    chk({tag, "_first_rise"}, first, D);
    chk({tag, "_valid"}, data_valid, 1);
    chk({tag, "_data"}, data, v);
  endtask

  task automatic handshake(input logic exp_arm, input string tag);
    @(negedge clk);
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
    chk({tag, "_hs_valid"}, data_valid, 0);
    chk({tag, "_hs_rc_same"}, rstcapt, 0);
    @(posedge clk); #1;
    chk({tag, "_hs_rc_next"}, rstcapt, exp_arm);
  endtask

  typedef struct {
    logic [W-1:0] cap;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n, r, g, a, b, c;
    logic ps;
    vecs[0] = '{cap: 8'h0A, exp: 8'h0A};
    vecs[1] = '{cap: 8'h80, exp: 8'h80};
    vecs[2] = '{cap: 8'hFF, exp: 8'hFF};
    vecs[3] = '{cap: 8'h01, exp: 8'h01};

    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_rstcapt", rstcapt, 0);
    chk("rst_data", data, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_arm(n);
    chk("arm_len", n, 2 * D);
    chk("arm_busy", busy, 1);

    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_arm(n);
      read_frame(vecs[i].cap, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_exp", i), data, vecs[i].exp);
      handshake(1'b1, $sformatf("vec%0d", i));
    end

    // consumer stalls while INT toggles
    wait_arm(n);
    read_frame(8'h55, "stall");
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 3 == 0) int_glitch = ~int_glitch;
      if (!data_valid) a++;
      if (!ce_n) b++;
      if (rstcapt) c++;
    end
    @(negedge clk);
    int_glitch = 1'b0;
    chk("stall_valid_drop", a, 0);
    chk("stall_ce_act", b, 0);
    chk("stall_rc_act", c, 0);
    chk("stall_data", data, 8'h55);
    handshake(1'b1, "stall");

    // reset mid-frame after 3 SCLK pulses
    wait_arm(n);
    @(negedge clk);
    cap_val = 8'h77;
    cap_seq++;
    r = 0; g = 0; ps = 1'b0;
    while (r < 3 && g < 500) begin
      @(posedge clk); #1;
      if (sclk && !ps) r++;
      ps = sclk;
      g++;
    end
    chk("mid_pulses", r, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ce_n", ce_n, 1);
    chk("mid_sclk", sclk, 0);
    chk("mid_valid", data_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_data", data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_arm(n);
    chk("mid_arm_len", n, 2 * D);
    read_frame(8'h09, "after_rst");

    // park in IDLE with INT high and EN low
    @(negedge clk);
    en = 1'b0;
    handshake(1'b0, "park");
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rstcapt) a++;
      if (!ce_n) b++;
      if (busy) c++;
    end
    chk("park_rc_act", a, 0);
    chk("park_ce_act", b, 0);
    chk("park_busy", c, 0);
    chk("park_data_kept", data, 8'h09);
    en = 1'b1;
    wait_arm(n);
    chk("resume_arm_len", n, 2 * D);
    read_frame(8'h3C, "resume");
    handshake(1'b1, "resume");

    chk("sclk_while_ce_high", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
